// File: rtl/pos_pkg.sv
// Shared types, constants and the per-axis step function for the position controller.
package pos_pkg;

    localparam int H_RIS   = 1280;
    localparam int V_RIS   = 1024;
    localparam int COORD_W = 11;
    localparam int CALC_W  = 12;
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        COMMIT
    } stato_t;

    typedef struct packed {
        logic [COORD_W-1:0] pos;
        logic               dir;
    } passo_t;

    // One step on a single axis: torus wrap in manual mode, clamped bounce otherwise.
    // All sums stay below 2*lim, so 12 bits never overflow.
    function automatic passo_t passo_asse(
        input logic [COORD_W-1:0] pos,
        input logic               dir,
        input logic               rimbalzo,
        input logic               piu,
        input logic               meno,
        input logic [CALC_W-1:0]  vel,
        input logic [CALC_W-1:0]  lim,
        input logic [CALC_W-1:0]  dim
    );
        logic [CALC_W-1:0] p;
        logic [CALC_W-1:0] p_max;
        logic [CALC_W-1:0] r_pos;
        passo_t            r;
        p     = {1'b0, pos};
        p_max = lim - dim;
        r_pos = p;
        r.dir = dir;
        if (!rimbalzo) begin
            if (piu && !meno) begin
                r_pos = (p + vel >= lim) ? (p + vel - lim) : (p + vel);
            end else if (meno && !piu) begin
                r_pos = (p < vel) ? (p + lim - vel) : (p - vel);
            end
        end else if (dir) begin
            if (p + vel > p_max) begin
                r_pos = p_max;
                r.dir = 1'b0;
            end else begin
                r_pos = p + vel;
            end
        end else begin
            // An object left beyond the right/bottom limit by manual wrap is pulled back first.
            if (p > p_max) begin
                r_pos = p_max;
            end else if (p < vel) begin
                r_pos = '0;
                r.dir = 1'b1;
            end else begin
                r_pos = p - vel;
            end
        end
        r.pos = r_pos[COORD_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/sincronizzatore_pulsante.sv
// Button input conditioning: 2-FF synchroniser followed by a sticky latch held until cleared.
module sincronizzatore_pulsante (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_async,
    input  logic clear,
    output logic premuto
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic latch_q, latch_d;

    // Next-state: the clear never drops a press that is still visible at the synchroniser output.
    always_comb begin
        sync1_d = btn_async;
        sync2_d = sync1_q;
        latch_d = clear ? sync2_q : (latch_q | sync2_q);
    end

    // Synchroniser and latch registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            latch_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            latch_q <= latch_d;
        end
    end

    // Including the live synchroniser output lets a press arriving during CALC count in this frame.
    assign premuto = latch_q | sync2_q;

endmodule

// File: rtl/controllo_posizione.sv
// Per-frame position controller: steps the object corner once per FRAME_END (every DIV_FRAME
// frames), in manual wrap-around or automatic bounce mode, and commits the result two cycles later.
module controllo_posizione
    import pos_pkg::*;
#(
    parameter int H         = H_RIS,
    parameter int V         = V_RIS,
    parameter int LARGHEZZA = 100,
    parameter int ALTEZZA   = 100,
    parameter int VEL       = 4,
    parameter int DIV_FRAME = 1,
    parameter int X_INIT    = 590,
    parameter int Y_INIT    = 462
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic               FRAME_END,
    input  logic               BTN_SU,
    input  logic               BTN_GIU,
    input  logic               BTN_SX,
    input  logic               BTN_DX,
    input  logic               MODO,
    input  logic               PAUSA,
    output logic [COORD_W-1:0] X_POS,
    output logic [COORD_W-1:0] Y_POS,
    output logic               DIR_X,
    output logic               DIR_Y,
    output logic               AGGIORNATO
);

    localparam logic [CALC_W-1:0]  VEL_C   = CALC_W'(VEL);
    localparam logic [CALC_W-1:0]  H_C     = CALC_W'(H);
    localparam logic [CALC_W-1:0]  V_C     = CALC_W'(V);
    localparam logic [CALC_W-1:0]  LARG_C  = CALC_W'(LARGHEZZA);
    localparam logic [CALC_W-1:0]  ALT_C   = CALC_W'(ALTEZZA);
    localparam logic [CNT_W-1:0]   CNT_ULT = CNT_W'(DIV_FRAME - 1);
    localparam logic [COORD_W-1:0] X_RST   = COORD_W'(X_INIT);
    localparam logic [COORD_W-1:0] Y_RST   = COORD_W'(Y_INIT);

    stato_t             stato_q, stato_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fe_q, fe_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0] xs_q, xs_d, ys_q, ys_d;
    logic               dirx_q, dirx_d, diry_q, diry_d;
    logic               dirxs_q, dirxs_d, dirys_q, dirys_d;
    logic               agg_q, agg_d;
    logic               clr;
    logic               fronte;
    logic               p_su, p_giu, p_sx, p_dx;
    passo_t             passo_x, passo_y;

    sincronizzatore_pulsante u_sync_su (
        .clk(CLOCK), .rst_n(RESET_N), .btn_async(BTN_SU),  .clear(clr), .premuto(p_su)
    );
    sincronizzatore_pulsante u_sync_giu (
        .clk(CLOCK), .rst_n(RESET_N), .btn_async(BTN_GIU), .clear(clr), .premuto(p_giu)
    );
    sincronizzatore_pulsante u_sync_sx (
        .clk(CLOCK), .rst_n(RESET_N), .btn_async(BTN_SX),  .clear(clr), .premuto(p_sx)
    );
    sincronizzatore_pulsante u_sync_dx (
        .clk(CLOCK), .rst_n(RESET_N), .btn_async(BTN_DX),  .clear(clr), .premuto(p_dx)
    );

    // Candidate next position for each axis, from the committed position and direction.
    always_comb begin
        passo_x = passo_asse(x_q, dirx_q, MODO, p_dx, p_sx, VEL_C, H_C, LARG_C);
        passo_y = passo_asse(y_q, diry_q, MODO, p_giu, p_su, VEL_C, V_C, ALT_C);
    end

    // FSM next-state: frame divider in IDLE, shadow capture in CALC, output load in COMMIT.
    always_comb begin
        stato_d = stato_q;
        cnt_d   = cnt_q;
        fe_d    = FRAME_END;
        x_d     = x_q;
        y_d     = y_q;
        dirx_d  = dirx_q;
        diry_d  = diry_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        dirxs_d = dirxs_q;
        dirys_d = dirys_q;
        agg_d   = 1'b0;
        clr     = 1'b0;
        fronte  = FRAME_END & ~fe_q;
        unique case (stato_q)
            IDLE: begin
                if (fronte && !PAUSA) begin
                    if (cnt_q == CNT_ULT) begin
                        stato_d = CALC;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CALC: begin
                xs_d    = passo_x.pos;
                dirxs_d = passo_x.dir;
                ys_d    = passo_y.pos;
                dirys_d = passo_y.dir;
                cnt_d   = '0;
                stato_d = COMMIT;
            end
            COMMIT: begin
                x_d     = xs_q;
                y_d     = ys_q;
                dirx_d  = dirxs_q;
                diry_d  = dirys_q;
                agg_d   = 1'b1;
                clr     = 1'b1;
                stato_d = IDLE;
            end
            default: begin
                stato_d = IDLE;
            end
        endcase
    end

    // State, counter, shadow and output registers.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            stato_q <= IDLE;
            cnt_q   <= '0;
            fe_q    <= 1'b0;
            x_q     <= X_RST;
            y_q     <= Y_RST;
            dirx_q  <= 1'b1;
            diry_q  <= 1'b1;
            xs_q    <= X_RST;
            ys_q    <= Y_RST;
            dirxs_q <= 1'b1;
            dirys_q <= 1'b1;
            agg_q   <= 1'b0;
        end else begin
            stato_q <= stato_d;
            cnt_q   <= cnt_d;
            fe_q    <= fe_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dirx_q  <= dirx_d;
            diry_q  <= diry_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            dirxs_q <= dirxs_d;
            dirys_q <= dirys_d;
            agg_q   <= agg_d;
        end
    end

    assign X_POS      = x_q;
    assign Y_POS      = y_q;
    assign DIR_X      = dirx_q;
    assign DIR_Y      = diry_q;
    assign AGGIORNATO = agg_q;

endmodule

// File: tb/tb_controllo_posizione.sv
// Scoreboard bench for controllo_posizione: stimulus pushes expected commits, monitors pop them.
module tb_controllo_posizione;

    localparam logic [3:0] B_DX  = 4'b0001;
    localparam logic [3:0] B_SX  = 4'b0010;
    localparam logic [3:0] B_GIU = 4'b0100;
    localparam logic [3:0] B_SU  = 4'b1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, fe, su, giu, sx, dx, modo, pausa;
    logic [10:0] x_pos, y_pos;
    logic        dir_x, dir_y, agg;
    logic        fe3, pausa3, dx3;
    logic [10:0] x3, y3;
    logic        dir_x3, dir_y3, agg3;

    int cyc = 0;
    int n_test = 0;
    int n_fail = 0;

    typedef struct {
        int cyc;
        int x;
        int y;
        int dx;
        int dy;
    } atteso_t;

    atteso_t q[$];
    atteso_t q3[$];

    controllo_posizione dut (
        .CLOCK(clk), .RESET_N(rst_n), .FRAME_END(fe),
        .BTN_SU(su), .BTN_GIU(giu), .BTN_SX(sx), .BTN_DX(dx),
        .MODO(modo), .PAUSA(pausa),
        .X_POS(x_pos), .Y_POS(y_pos), .DIR_X(dir_x), .DIR_Y(dir_y), .AGGIORNATO(agg)
    );

    controllo_posizione #(.DIV_FRAME(3)) dut3 (
        .CLOCK(clk), .RESET_N(rst_n), .FRAME_END(fe3),
        .BTN_SU(1'b0), .BTN_GIU(1'b0), .BTN_SX(1'b0), .BTN_DX(dx3),
        .MODO(1'b0), .PAUSA(pausa3),
        .X_POS(x3), .Y_POS(y3), .DIR_X(dir_x3), .DIR_Y(dir_y3), .AGGIORNATO(agg3)
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nome, input int act, input int exp);
        n_test++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nome, act, exp, cyc);
        end
    endfunction

    // Monitor for the DIV_FRAME=1 instance.
    always @(negedge clk) begin
        if (agg === 1'b1) begin
            if (q.size() == 0) begin
                chk("agg_unexpected", 1, 0);
            end else begin
                atteso_t e;
                e = q.pop_front();
                chk("agg_latency", cyc, e.cyc);
                chk("x_pos", int'(x_pos), e.x);
                chk("y_pos", int'(y_pos), e.y);
                chk("dir_x", int'(dir_x), e.dx);
                chk("dir_y", int'(dir_y), e.dy);
            end
        end
    end

    // Monitor for the DIV_FRAME=3 instance.
    always @(negedge clk) begin
        if (agg3 === 1'b1) begin
            if (q3.size() == 0) begin
                chk("agg3_unexpected", 1, 0);
            end else begin
                atteso_t e;
                e = q3.pop_front();
                chk("agg3_latency", cyc, e.cyc);
                chk("x3_pos", int'(x3), e.x);
                chk("y3_pos", int'(y3), e.y);
            end
        end
    end

    task automatic frame_step(input logic [3:0] btn, input int ex, input int ey,
                              input int edx, input int edy);
        atteso_t e;
        {su, giu, sx, dx} = btn;
        repeat (3) @(posedge clk);
        #1;
        fe = 1'b1;
        {su, giu, sx, dx} = 4'b0000;
        e.cyc = cyc + 3;
        e.x = ex;
        e.y = ey;
        e.dx = edx;
        e.dy = edy;
        q.push_back(e);
        @(posedge clk);
        #1 fe = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic frame_nostep();
        repeat (3) @(posedge clk);
        #1 fe = 1'b1;
        @(posedge clk);
        #1 fe = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic frame3(input logic p, input logic passo, input int ex);
        atteso_t e;
        repeat (3) @(posedge clk);
        #1;
        fe3 = 1'b1;
        pausa3 = p;
        if (passo) begin
            e.cyc = cyc + 3;
            e.x = ex;
            e.y = 462;
            e.dx = 1;
            e.dy = 1;
            q3.push_back(e);
        end
        @(posedge clk);
        #1;
        fe3 = 1'b0;
        pausa3 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        fe = 1'b0; su = 1'b0; giu = 1'b0; sx = 1'b0; dx = 1'b0;
        modo = 1'b0; pausa = 1'b0;
        fe3 = 1'b0; pausa3 = 1'b0; dx3 = 1'b0;

        // Reset state, then idle without FRAME_END
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", int'(x_pos), 590);
        chk("rst_y", int'(y_pos), 462);
        chk("rst_dir_x", int'(dir_x), 1);
        chk("rst_dir_y", int'(dir_y), 1);
        chk("rst_agg", int'(agg), 0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("idle_x", int'(x_pos), 590);
        chk("idle_y", int'(y_pos), 462);

        // Manual steps
        frame_step(B_DX, 594, 462, 1, 1);
        frame_step(B_DX, 598, 462, 1, 1);
        frame_step(B_DX, 602, 462, 1, 1);
        frame_step(B_GIU, 602, 466, 1, 1);
        frame_step(B_SU, 602, 462, 1, 1);
        frame_step(B_SX | B_DX, 602, 462, 1, 1);

        // Walk left down to X=2, then wrap both ways
        for (int k = 1; k <= 150; k++) frame_step(B_SX, 602 - 4 * k, 462, 1, 1);
        frame_step(B_SX, 1278, 462, 1, 1);
        frame_step(B_DX, 2, 462, 1, 1);
        frame_step(B_SX, 1278, 462, 1, 1);
        for (int k = 1; k <= 25; k++) frame_step(B_SX, 1278 - 4 * k, 462, 1, 1);

        // Bounce at the right limit; buttons ignored
        modo = 1'b1;
        frame_step(4'b0000, 1180, 466, 0, 1);
        frame_step(B_DX, 1176, 470, 0, 1);

        // Pause suppresses the step; manual mode keeps directions
        modo = 1'b0;
        pausa = 1'b1;
        frame_nostep();
        chk("pause_x", int'(x_pos), 1176);
        pausa = 1'b0;
        frame_step(B_DX, 1180, 470, 0, 1);

        // Reset asserted while in CALC
        #0;
        repeat (2) @(posedge clk);
        #1 fe = 1'b1;
        @(posedge clk);
        #1 fe = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("calc_rst_x", int'(x_pos), 590);
        chk("calc_rst_y", int'(y_pos), 462);
        chk("calc_rst_dir_x", int'(dir_x), 1);
        chk("calc_rst_agg", int'(agg), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_x", int'(x_pos), 590);

        // Two-clock press mid-frame is applied at the next FRAME_END
        dx = 1'b1;
        repeat (2) @(posedge clk);
        #1 dx = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        frame_step(4'b0000, 594, 462, 1, 1);

        // DIV_FRAME=3 with a pause on frame 2
        dx3 = 1'b1;
        frame3(1'b0, 1'b0, 0);
        frame3(1'b1, 1'b0, 0);
        frame3(1'b0, 1'b0, 0);
        chk("div3_hold_x", int'(x3), 590);
        frame3(1'b0, 1'b1, 594);
        frame3(1'b0, 1'b0, 0);
        frame3(1'b0, 1'b0, 0);
        chk("div3_wait_x", int'(x3), 594);
        frame3(1'b0, 1'b1, 598);
        dx3 = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 0);
        chk("queue3_empty", q3.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

endmodule
